fetch_controller: RTL and testbench

Sequences the RV32I program counter and instruction fetch for the minimal core. Owns the architectural PC, issues one request at a time to instruction memory over a request/acknowledge handshake, and holds each fetched word for decode until decode accepts it. Sits between the program counter datapath, instruction memory and decode. Accepts branch/jump redirects from execute.

---
 rtl/riscv_core_pkg.sv | 19 +
 rtl/fetch_pc_next.sv | 25 ++
 rtl/fetch_controller.sv | 94 +++++++++
 tb/tb_fetch_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_pkg.sv
// Shared definitions for the minimal RV32I core: data width, PC step,
// default reset vector and the fetch FSM state encoding.
package riscv_core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_HOLD = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select: a redirect wins over sequential advance,
// otherwise the PC holds. Also flags a misaligned redirect target.
module fetch_pc_next
    import riscv_core_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            advance,
    output logic [XLEN-1:0] next_pc,
    output logic            target_misaligned
);

    always_comb begin
        next_pc           = pc;
        target_misaligned = 1'b0;
        if (redirect_valid) begin
            next_pc           = redirect_target;
            target_misaligned = is_misaligned(redirect_target);
        end else if (advance) begin
            next_pc = pc + PC_STEP;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the architectural PC, runs one
// request/ack fetch at a time and holds each word until decode takes it.
module fetch_controller
    import riscv_core_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] pc,
    output logic        misaligned
);

    fetch_state_t state;
    logic [31:0]  next_pc;
    logic         target_misaligned;
    logic         advance;
    logic         take_redirect;

    // Redirects are ignored once halted; only reset leaves HALT.
    assign take_redirect = redirect_valid && (state != FETCH_HALT);
    assign advance       = (state == FETCH_HOLD) && inst_ready;

    fetch_pc_next u_pc_next (
        .pc                (pc),
        .redirect_valid    (take_redirect),
        .redirect_target   (redirect_target),
        .advance           (advance),
        .next_pc           (next_pc),
        .target_misaligned (target_misaligned)
    );

    assign imem_req   = (state == FETCH_REQ);
    assign imem_addr  = pc;
    assign inst_valid = (state == FETCH_HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FETCH_REQ;
            pc          <= RESET_VECTOR;
            instruction <= 32'h0;
            inst_pc     <= 32'h0;
            misaligned  <= 1'b0;
        end else begin
            case (state)
                FETCH_REQ: begin
                    // A redirect discards any word returned in the same cycle.
                    if (take_redirect) begin
                        pc <= next_pc;
                        if (target_misaligned) begin
                            misaligned <= 1'b1;
                            state      <= FETCH_HALT;
                        end
                    end else if (imem_ack) begin
                        instruction <= imem_rdata;
                        inst_pc     <= pc;
                        state       <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (take_redirect) begin
                        pc <= next_pc;
                        if (target_misaligned) begin
                            misaligned <= 1'b1;
                            state      <= FETCH_HALT;
                        end else begin
                            state <= FETCH_REQ;
                        end
                    end else if (inst_ready) begin
                        pc    <= next_pc;
                        state <= FETCH_REQ;
                    end
                end
                FETCH_HALT: begin
                    state <= FETCH_HALT;
                end
                default: begin
                    state <= FETCH_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: linear steps with hand-computed
// expectations and a simple address-derived instruction memory.
module tb_fetch_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    assign imem_rdata = imem_ack ? memword(imem_addr) : 32'hDEAD_BEEF;

    fetch_controller #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instruction     (instruction),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .pc              (pc),
        .misaligned      (misaligned)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        tick();
        tick();
        check("rst_req", {31'b0, imem_req}, 32'd1);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_instpc", inst_pc, 32'h0);
        check("rst_misal", {31'b0, misaligned}, 32'd0);

        // Streaming with ack and ready tied high
        reset = 1'b0;
        imem_ack = 1'b1;
        inst_ready = 1'b1;
        #1;
        check("s0_req", {31'b0, imem_req}, 32'd1);
        check("s0_addr", imem_addr, 32'h0);
        tick();
        check("s0_valid", {31'b0, inst_valid}, 32'd1);
        check("s0_req_lo", {31'b0, imem_req}, 32'd0);
        check("s0_instr", instruction, memword(32'h0));
        check("s0_instpc", inst_pc, 32'h0);
        tick();
        check("s1_addr", imem_addr, 32'h4);
        check("s1_req", {31'b0, imem_req}, 32'd1);
        tick();
        check("s1_instr", instruction, memword(32'h4));
        check("s1_instpc", inst_pc, 32'h4);
        tick();
        check("s2_addr", imem_addr, 32'h8);
        tick();
        check("s2_instr", instruction, memword(32'h8));
        check("s2_instpc", inst_pc, 32'h8);
        imem_ack = 1'b0;
        tick();
        inst_ready = 1'b0;

        // Late ack (3 cycles) then decode stall (2 cycles)
        for (int i = 0; i < 4; i++) begin
            check("late_req", {31'b0, imem_req}, 32'd1);
            check("late_addr", imem_addr, 32'hC);
            if (i == 3) imem_ack = 1'b1;
            tick();
        end
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'b0, inst_valid}, 32'd1);
            check("stall_instr", instruction, memword(32'hC));
            check("stall_instpc", inst_pc, 32'hC);
            check("stall_pc", pc, 32'hC);
            if (i == 2) inst_ready = 1'b1;
            tick();
        end
        inst_ready = 1'b0;
        check("accept_pc", pc, 32'h10);
        check("accept_req", {31'b0, imem_req}, 32'd1);

        // Redirect in REQ with simultaneous ack
        imem_ack = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        check("rdq_valid", {31'b0, inst_valid}, 32'd0);
        check("rdq_req", {31'b0, imem_req}, 32'd1);
        check("rdq_addr", imem_addr, 32'h100);
        check("rdq_instr", instruction, memword(32'hC));
        check("rdq_instpc", inst_pc, 32'hC);

        // Redirect in HOLD without ready
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("rdh_held", instruction, memword(32'h100));
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("rdh_valid", {31'b0, inst_valid}, 32'd0);
        check("rdh_req", {31'b0, imem_req}, 32'd1);
        check("rdh_addr", imem_addr, 32'h200);

        // Misaligned redirect halts until reset
        redirect_valid = 1'b1;
        redirect_target = 32'h0000_0102;
        tick();
        check("mis_flag", {31'b0, misaligned}, 32'd1);
        check("mis_pc", pc, 32'h102);
        imem_ack = 1'b1;
        inst_ready = 1'b1;
        redirect_target = 32'h300;
        for (int i = 0; i < 10; i++) begin
            check("halt_req", {31'b0, imem_req}, 32'd0);
            check("halt_valid", {31'b0, inst_valid}, 32'd0);
            check("halt_misal", {31'b0, misaligned}, 32'd1);
            tick();
        end
        check("halt_pc", pc, 32'h102);
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("halt_rst_pc", pc, 32'h0);
        check("halt_rst_misal", {31'b0, misaligned}, 32'd0);
        check("halt_rst_req", {31'b0, imem_req}, 32'd1);

        // PC wraps modulo 2^32
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("wrap_instpc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_instr", instruction, memword(32'hFFFF_FFFC));
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("wrap_next", imem_addr, 32'h0);
        check("wrap_req", {31'b0, imem_req}, 32'd1);

        // Reset while a request is outstanding
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("mid_addr", imem_addr, 32'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_req", {31'b0, imem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
